// File: rtl/stream_mux_n.sv
// N-input registered stream selector with valid/ready handshakes.
// Fixed (sel-driven) or round-robin source selection; reports the supplying channel.
module stream_mux_n #(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int RR_MODE = 0,
    parameter int SEL_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_chan
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] chan_data [N];
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             en;
    logic             xfer;

    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] out_chan_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    assign en = !out_valid_reg || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi]  = grant[gi] & en;
        end
    endgenerate

    // Fixed mode: out-of-range sel grants nothing. Round-robin: first valid from ptr upward, wrapping.
    always_comb begin : grant_logic
        int  scan_idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i)) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                scan_idx = (int'(ptr_reg) + o) % N;
                if (!found && in_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = SEL_W'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = chan_data[i];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            if (grant_idx == SEL_W'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = PTR_W'(grant_idx) + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_chan_reg  <= '0;
            ptr_reg       <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (en) begin
                if (xfer) begin
                    out_data_reg  <= sel_data;
                    out_chan_reg  <= grant_idx;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_chan  = out_chan_reg;

endmodule
